battle_input_arbiter: RTL and testbench
=======================================

// Module: battle_input_arbiter
// PURPOSE
//  Shares the single extended-button command channel between two players.
//  Grants one player at a time (round-robin) and latches that player's button as one-hot.
//  Holds the button for EXTEND_RATE+1 cycles, then offers it to the battle FSM with a valid/ack handshake.
//  Waits for the granted player to release before the channel can be granted again.
//  Sits between the raw button synchronisers and the battle game FSM.
// PARAMETERS
//  BTN_W        6      button vector width per player
//  CNT_W        8      hold-counter width
//  EXTEND_RATE  8'hFF  final hold count; hold lasts EXTEND_RATE+1 cycles
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous reset, active-low
//  p1_btn       in   BTN_W  player-1 buttons, synchronised, 1 = pressed
//  p2_btn       in   BTN_W  player-2 buttons, synchronised
//  p1_en        in   1      player-1 allowed to request (turn gating)
//  p2_en        in   1      player-2 allowed to request
//  abort        in   1      synchronous drop of the current grant
//  cmd_ack      in   1      battle FSM consumed cmd
//  ext_btn      out  BTN_W  one-hot latched button, nonzero while busy
//  ext_active   out  1      high in HOLD
//  hold_count   out  CNT_W  current hold count
//  cmd_valid    out  1      high in WAIT_ACK
//  cmd_player   out  1      0 = P1, 1 = P2; valid whenever ext_btn != 0
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; last_grant = P2, so P1 wins the first tie.
//  A player requests when its enable is high and its button vector is nonzero.
//  States:
//   IDLE: if any player requests, register the winner, latch the lowest set bit of its vector
//    as one-hot, count = 0, go to HOLD.
//    - Both requesting: grant the player not equal to last_grant.
//   HOLD: ext_active = 1; count increments each cycle.
//    - When count == EXTEND_RATE: go to WAIT_ACK, count holds.
//    - Button release and enable drop during HOLD are ignored; the hold always completes.
//   WAIT_ACK: cmd_valid = 1; ext_btn and cmd_player stable.
//    - cmd_ack = 1: go to REL. cmd_ack is ignored in every other state.
//   REL: ext_btn and cmd_player still driven, cmd_valid = 0.
//    - When the granted player's raw vector == 0: go to IDLE, last_grant = granted player,
//      clear ext_btn and count.
//  Latency: request sampled at edge k; HOLD from cycle k+1; cmd_valid first high at cycle k+2+EXTEND_RATE.
//  EXTEND_RATE = 0: HOLD lasts exactly 1 cycle.
//  abort = 1: in any non-IDLE state, go to IDLE next edge, clear outputs, last_grant = granted player.
//   abort has priority over cmd_ack. In IDLE, abort blocks new grants that cycle.
//  Counter never wraps: it saturates at EXTEND_RATE. CNT_W must hold EXTEND_RATE.
//  Reset mid-operation: immediate return to the reset state; no cmd is emitted.
//  A player's held button never re-triggers; a new grant requires passing through REL.
// STRUCTURE
//  Shared package battle_pkg:
//   - state encoding IDLE/HOLD/WAIT_ACK/REL
//   - PLAYER_1 = 1'b0, PLAYER_2 = 1'b1
//   - default EXTEND_RATE constant
//  One sub-module: arb_hold_counter (clear, enable, saturating at EXTEND_RATE, done flag).
//  Priority encoder and round-robin logic stay in this module.
// TESTING
//  1. EXTEND_RATE = 3; p1_btn = 6'b000100 for 1 cycle ->
//     ext_active for 4 cycles, cmd_valid at cycle 5, ext_btn = 6'b000100, cmd_player = 0.
//  2. p1_btn = 6'b010110 ->
//     ext_btn = 6'b000010, the lowest set bit.
//  3. p1 and p2 press in the same cycle, both enabled ->
//     P1 granted; after ack and release both press again -> P2 granted.
//  4. p2_en = 0, p2_btn = 6'b100000 ->
//     no grant; raise p2_en -> grant P2 next edge.
//  5. cmd_ack withheld 10 cycles ->
//     cmd_valid and ext_btn stable; ack with button still held -> stays in REL until p1_btn = 0.
//  6. abort at hold_count = 2, and separately reset low mid-HOLD ->
//     IDLE with all outputs 0, no cmd_valid pulse.

Source files
------------

// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : battle_pkg
// Brief    : Shared state encoding, player ids and defaults for the battle
//            input arbiter.
// Revision : 1.0
// ============================================================================
package battle_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_HOLD     = 2'd1;
    localparam state_t ST_WAIT_ACK = 2'd2;
    localparam state_t ST_REL      = 2'd3;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam int unsigned DEFAULT_EXTEND_RATE = 32'h0000_00FF;

endpackage
`default_nettype wire

// File: rtl/battle_input_arbiter_hold_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_hold_counter
// Brief    : Hold-time counter with clear/enable that saturates at EXTEND_RATE.
// Revision : 1.0
// ============================================================================
module arb_hold_counter #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXTEND_RATE = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(EXTEND_RATE);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign done  = (count_q == C_LIMIT);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/battle_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : battle_input_arbiter
// Brief    : Round-robin grant of the shared extended-button channel between
//            two players, with hold timing and a valid/ack command handshake.
// Revision : 1.0
// ============================================================================
module battle_input_arbiter
    import battle_pkg::*;
#(
    parameter int unsigned BTN_W       = 6,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned EXTEND_RATE = DEFAULT_EXTEND_RATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BTN_W-1:0] p1_btn,
    input  logic [BTN_W-1:0] p2_btn,
    input  logic             p1_en,
    input  logic             p2_en,
    input  logic             abort,
    input  logic             cmd_ack,
    output logic [BTN_W-1:0] ext_btn,
    output logic             ext_active,
    output logic [CNT_W-1:0] hold_count,
    output logic             cmd_valid,
    output logic             cmd_player
);

    state_t           state_q, state_d;
    logic [BTN_W-1:0] ext_btn_q, ext_btn_d;
    logic             player_q, player_d;
    logic             last_grant_q, last_grant_d;

    logic             w_p1_req;
    logic             w_p2_req;
    logic             w_winner;
    logic [BTN_W-1:0] w_win_vec;
    logic [BTN_W-1:0] w_win_onehot;
    logic [BTN_W-1:0] w_granted_vec;
    logic             w_release;
    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic             w_cnt_done;

    assign w_p1_req = p1_en && (p1_btn != '0);
    assign w_p2_req = p2_en && (p2_btn != '0);

    // On a tie the player who did not hold the channel last time wins.
    assign w_winner     = (w_p1_req && w_p2_req) ? ~last_grant_q
                        : (w_p2_req ? PLAYER_2 : PLAYER_1);
    assign w_win_vec    = (w_winner == PLAYER_2) ? p2_btn : p1_btn;
    assign w_win_onehot = w_win_vec & (~w_win_vec + BTN_W'(1));

    assign w_granted_vec = (player_q == PLAYER_2) ? p2_btn : p1_btn;
    assign w_release     = (state_q == ST_REL) && (w_granted_vec == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ext_btn_d    = ext_btn_q;
        player_d     = player_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (!abort && (w_p1_req || w_p2_req)) begin
                    state_d   = ST_HOLD;
                    player_d  = w_winner;
                    ext_btn_d = w_win_onehot;
                end
            end
            ST_HOLD: begin
                if (w_cnt_done) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (cmd_ack) begin
                    state_d = ST_REL;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        // Abort and release share one exit path and outrank any ack.
        if ((state_q != ST_IDLE) && (abort || w_release)) begin
            state_d      = ST_IDLE;
            ext_btn_d    = '0;
            player_d     = PLAYER_1;
            last_grant_d = player_q;
        end
    end

    always_comb begin
        ext_active  = (state_q == ST_HOLD);
        cmd_valid   = (state_q == ST_WAIT_ACK);
        w_cnt_en    = (state_q == ST_HOLD);
        w_cnt_clear = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_btn_q    <= '0;
            player_q     <= PLAYER_1;
            last_grant_q <= PLAYER_2;
        end else begin
            ext_btn_q    <= ext_btn_d;
            player_q     <= player_d;
            last_grant_q <= last_grant_d;
        end
    end

    arb_hold_counter #(
        .CNT_W       (CNT_W),
        .EXTEND_RATE (EXTEND_RATE)
    ) u_hold_counter (
        .clk   (clk),
        .rst_n (reset),
        .clear (w_cnt_clear),
        .en    (w_cnt_en),
        .count (hold_count),
        .done  (w_cnt_done)
    );

    assign ext_btn    = ext_btn_q;
    assign cmd_player = player_q;

endmodule
`default_nettype wire

// File: tb/tb_battle_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_battle_input_arbiter
// Brief    : Directed and random checks of two arbiter instances (EXTEND_RATE
//            3 and 0) against an age-based behavioural model.
// Revision : 1.0
// ============================================================================
module tb_battle_input_arbiter;

    localparam int BTN_W = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [BTN_W-1:0] p1_btn, p2_btn;
    logic             p1_en, p2_en, abort, cmd_ack;

    logic [BTN_W-1:0] ext_btn_o    [2];
    logic             ext_active_o [2];
    logic [CNT_W-1:0] hold_count_o [2];
    logic             cmd_valid_o  [2];
    logic             cmd_player_o [2];

    int checks   = 0;
    int failures = 0;

    // Model: a grant is described by its age in cycles since the grant edge.
    bit               m_busy   [2];
    bit               m_acked  [2];
    bit               m_player [2];
    bit               m_last   [2];
    int               m_age    [2];
    logic [BTN_W-1:0] m_btn    [2];
    int               c_er     [2] = '{3, 0};

    always #5 clk = ~clk;

    battle_input_arbiter #(.BTN_W(BTN_W), .CNT_W(CNT_W), .EXTEND_RATE(3)) u_dut (
        .clk(clk), .reset(reset), .p1_btn(p1_btn), .p2_btn(p2_btn),
        .p1_en(p1_en), .p2_en(p2_en), .abort(abort), .cmd_ack(cmd_ack),
        .ext_btn(ext_btn_o[0]), .ext_active(ext_active_o[0]),
        .hold_count(hold_count_o[0]), .cmd_valid(cmd_valid_o[0]),
        .cmd_player(cmd_player_o[0])
    );

    battle_input_arbiter #(.BTN_W(BTN_W), .CNT_W(CNT_W), .EXTEND_RATE(0)) u_dut_er0 (
        .clk(clk), .reset(reset), .p1_btn(p1_btn), .p2_btn(p2_btn),
        .p1_en(p1_en), .p2_en(p2_en), .abort(abort), .cmd_ack(cmd_ack),
        .ext_btn(ext_btn_o[1]), .ext_active(ext_active_o[1]),
        .hold_count(hold_count_o[1]), .cmd_valid(cmd_valid_o[1]),
        .cmd_player(cmd_player_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BTN_W-1:0] lowest_bit(input logic [BTN_W-1:0] v);
        logic [BTN_W-1:0] r;
        r = '0;
        for (int b = 0; b < BTN_W; b++) begin
            if (v[b] && (r == '0)) r[b] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_acked[i] = 0; m_player[i] = 0;
            m_last[i] = 1; m_age[i] = 0; m_btn[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit r1, r2, pick;
        r1 = p1_en && (p1_btn != '0);
        r2 = p2_en && (p2_btn != '0);
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (!abort && (r1 || r2)) begin
                    pick        = (r1 && r2) ? !m_last[i] : r2;
                    m_busy[i]   = 1;
                    m_player[i] = pick;
                    m_btn[i]    = lowest_bit(pick ? p2_btn : p1_btn);
                    m_age[i]    = 0;
                    m_acked[i]  = 0;
                end
            end else if (abort) begin
                m_busy[i] = 0;
                m_last[i] = m_player[i];
            end else if (m_acked[i]) begin
                if ((m_player[i] ? p2_btn : p1_btn) == '0) begin
                    m_busy[i] = 0;
                    m_last[i] = m_player[i];
                end
            end else begin
                if (m_age[i] > c_er[i] && cmd_ack) m_acked[i] = 1;
                if (m_age[i] <= c_er[i]) m_age[i]++;
            end
        end
    endtask

    task automatic compare_all();
        int cnt;
        for (int i = 0; i < 2; i++) begin
            cnt = !m_busy[i] ? 0 : (m_age[i] > c_er[i] ? c_er[i] : m_age[i]);
            check_eq($sformatf("ext_btn[%0d]", i), 32'(ext_btn_o[i]),
                     m_busy[i] ? 32'(m_btn[i]) : 32'd0);
            check_eq($sformatf("cmd_player[%0d]", i), 32'(cmd_player_o[i]),
                     32'(m_busy[i] && m_player[i]));
            check_eq($sformatf("ext_active[%0d]", i), 32'(ext_active_o[i]),
                     32'(m_busy[i] && !m_acked[i] && m_age[i] <= c_er[i]));
            check_eq($sformatf("cmd_valid[%0d]", i), 32'(cmd_valid_o[i]),
                     32'(m_busy[i] && !m_acked[i] && m_age[i] > c_er[i]));
            check_eq($sformatf("hold_count[%0d]", i), 32'(hold_count_o[i]), 32'(cnt));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges and held across one edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        #2 reset = 1'b1;
    endtask

    task automatic finish_grant();
        p1_btn = '0; p2_btn = '0;
        repeat (5) step();
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        step();
        step();
    endtask

    initial begin
        int act_n, first_valid;
        reset = 1'b0; p1_btn = '0; p2_btn = '0;
        p1_en = 1'b1; p2_en = 1'b1; abort = 1'b0; cmd_ack = 1'b0;
        #3 model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Simultaneous press: P1 first, then P2 on the next tie.
        p1_btn = 6'b000001; p2_btn = 6'b000001;
        step();
        check_eq("t3_first_tie_player", 32'(cmd_player_o[0]), 32'd0);
        finish_grant();
        p1_btn = 6'b000001; p2_btn = 6'b000001;
        step();
        check_eq("t3_second_tie_player", 32'(cmd_player_o[0]), 32'd1);
        finish_grant();

        // Single-cycle press: hold length and first valid cycle.
        act_n = 0; first_valid = 0;
        p1_btn = 6'b000100;
        for (int j = 1; j <= 7; j++) begin
            step();
            p1_btn = '0;
            if (ext_active_o[0]) act_n++;
            if (cmd_valid_o[0] && first_valid == 0) first_valid = j;
        end
        check_eq("t1_active_cycles", 32'(act_n), 32'd4);
        check_eq("t1_first_valid", 32'(first_valid), 32'd5);
        check_eq("t1_ext_btn", 32'(ext_btn_o[0]), 32'b000100);
        check_eq("t1_player", 32'(cmd_player_o[0]), 32'd0);
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0; step(); step();

        // Lowest set bit selection.
        p1_btn = 6'b010110;
        step();
        check_eq("t2_lowest_bit", 32'(ext_btn_o[0]), 32'b000010);
        finish_grant();

        // Enable gating.
        p1_btn = '0; p2_en = 1'b0; p2_btn = 6'b100000;
        step();
        check_eq("t4_no_grant", 32'(ext_btn_o[0]), 32'd0);
        p2_en = 1'b1;
        step();
        check_eq("t4_grant_player", 32'(cmd_player_o[0]), 32'd1);
        check_eq("t4_grant_btn", 32'(ext_btn_o[0]), 32'b100000);
        finish_grant();

        // Withheld ack, then ack with button still held.
        p1_btn = 6'b000001;
        repeat (5) step();
        repeat (10) begin
            step();
            check_eq("t5_valid_stable", 32'(cmd_valid_o[0]), 32'd1);
            check_eq("t5_btn_stable", 32'(ext_btn_o[0]), 32'd1);
        end
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        repeat (3) begin
            step();
            check_eq("t5_rel_no_valid", 32'(cmd_valid_o[0]), 32'd0);
            check_eq("t5_rel_btn", 32'(ext_btn_o[0]), 32'd1);
        end
        p1_btn = '0;
        step();
        check_eq("t5_released", 32'(ext_btn_o[0]), 32'd0);

        // Abort mid-hold, then reset mid-hold.
        p1_btn = 6'b000001;
        repeat (3) step();
        check_eq("t6_count_at_abort", 32'(hold_count_o[0]), 32'd2);
        abort = 1'b1; p1_btn = '0;
        step();
        abort = 1'b0;
        check_eq("t6_abort_btn", 32'(ext_btn_o[0]), 32'd0);
        repeat (4) begin
            step();
            check_eq("t6_abort_no_valid", 32'(cmd_valid_o[0]), 32'd0);
        end
        p1_btn = 6'b001000;
        repeat (2) step();
        p1_btn = '0;
        do_reset();
        check_eq("t6_reset_active", 32'(ext_active_o[0]), 32'd0);
        repeat (6) step();

        // Randomised traffic.
        for (int n = 0; n < 2500; n++) begin
            p1_btn  = $urandom_range(0, 1) ? BTN_W'($urandom) : '0;
            p2_btn  = $urandom_range(0, 1) ? BTN_W'($urandom) : '0;
            p1_en   = ($urandom_range(0, 9) != 0);
            p2_en   = ($urandom_range(0, 9) != 0);
            cmd_ack = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
